inject_q: RTL

// - Parametrised successor of the single-slot injector: buffers locally generated flits in a

---
 rtl/inject_q.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/inject_q.sv
// Injection queue: buffers NI flits in a small FIFO and merges the head into an idle router channel.
// Define INJECT_RR_EN for round-robin channel selection; the default is lowest-index-idle priority.
package inject_q_pkg;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } flit_int_t;
endpackage

module inject_q
  import inject_q_pkg::*;
#(
  parameter int NUM_CHNL    = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int STARVE_TH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  flit_int_t                      din_inject,
  input  logic                           inject_vld,
  output logic                           inject_rdy,
  input  flit_int_t                      din  [NUM_CHNL],
  output flit_int_t                      dout [NUM_CHNL],
  output logic                           inject_gnt,
  output logic                           starve,
  output logic [$clog2(QUEUE_DEPTH):0]   q_cnt
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1;
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_TH);

  flit_int_t           mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic [NUM_CHNL-1:0] idle;
  logic [NUM_CHNL-1:0] sel;
  flit_int_t           head;
  logic [7:0]          starve_cnt;
  logic [7:0]          starve_cnt_nxt;

  assign empty      = (q_cnt == '0);
  assign full       = (q_cnt == CNT_W'(QUEUE_DEPTH));
  assign inject_rdy = ~full;
  assign push       = inject_vld & inject_rdy;
  // Gating with reset keeps the head off dout from the instant reset rises.
  assign pop        = ~reset & ~empty & (|idle);
  assign inject_gnt = pop;
  assign head       = mem[rd_ptr];

  always_comb begin
    idle = '0;
    for (int i = 0; i < NUM_CHNL; i++) idle[i] = ~din[i].vld;
  end

`ifdef INJECT_RR_EN
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] gnt_idx;
  logic            found;
  int              rr_idx;

  always_comb begin
    sel     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    rr_idx  = 0;
    for (int k = 0; k < NUM_CHNL; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_CHNL) rr_idx = rr_idx - NUM_CHNL;
      if (!found && idle[rr_idx]) begin
        found       = 1'b1;
        sel[rr_idx] = 1'b1;
        gnt_idx     = CH_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (pop) begin
      rr_ptr <= (gnt_idx == CH_W'(NUM_CHNL - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end
`else
  // Scanning downwards lets the lowest idle index overwrite any higher one.
  always_comb begin
    sel = '0;
    for (int i = NUM_CHNL - 1; i >= 0; i--) begin
      if (idle[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_CHNL; i++) dout[i] = (pop && sel[i]) ? head : din[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din_inject;
  end

  // A non-empty queue that did not pop this cycle means every channel was occupied.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (empty || pop)                starve_cnt_nxt = '0;
    else if (starve_cnt != STARVE_MAX) starve_cnt_nxt = starve_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      starve     <= (starve_cnt_nxt == STARVE_MAX);
    end
  end

endmodule
